// File: rtl/adaptive_slicer.sv
// adaptive_slicer: 4-ASK I/Q slicer with a block-averaged reference level (mean |x|).
// Optional macro SLICER_ERROR_OUT_EN compiles in the registered slicing-error outputs.
`default_nettype none

module adaptive_slicer #(
  parameter int                 ACC_LOG2 = 18,
  parameter logic signed [17:0] INIT_REF = 18'sd32768
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic signed [17:0] dec_in_I,
  input  logic signed [17:0] dec_in_Q,
  output logic [1:0]         slicer_out_I,
  output logic [1:0]         slicer_out_Q,
  output logic               sym_valid,
  output logic [17:0]        ref_level,
  output logic               ref_valid,
  output logic signed [17:0] error_I,
  output logic signed [17:0] error_Q
);

  localparam int ACC_W = 19 + ACC_LOG2;

  logic                sym_en;
  logic [16:0]         abs_i;
  logic [16:0]         abs_q;
  logic [17:0]         abs_sum;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nxt;
  logic [ACC_LOG2-1:0] cnt;
  logic [1:0]          dec_i;
  logic [1:0]          dec_q;

  // Symbol enable is always coincident with a sample enable.
  assign sym_en = sym_clk_en & sam_clk_en;

  // Saturating magnitude: the most negative code maps to +131071.
  function automatic logic [16:0] abs_sat(input logic signed [17:0] x);
    logic [17:0] neg;
    neg = -x;
    if (x == -18'sd131072) return 17'h1ffff;
    else if (x[17])        return neg[16:0];
    else                   return x[16:0];
  endfunction

  function automatic logic [1:0] slice(input logic signed [17:0] x, input logic [17:0] r);
    logic signed [19:0] xs;
    logic signed [19:0] rs;
    xs = {{2{x[17]}}, x};
    rs = {2'b00, r};
    if (xs < -rs)      return 2'b00;
    else if (x[17])    return 2'b01;
    else if (xs < rs)  return 2'b10;
    else               return 2'b11;
  endfunction

  assign abs_i   = abs_sat(dec_in_I);
  assign abs_q   = abs_sat(dec_in_Q);
  assign abs_sum = {1'b0, abs_i} + {1'b0, abs_q};
  assign acc_nxt = acc + ACC_W'(abs_sum);
  assign dec_i   = slice(dec_in_I, ref_level);
  assign dec_q   = slice(dec_in_Q, ref_level);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      slicer_out_I <= 2'b10;
      slicer_out_Q <= 2'b10;
      sym_valid    <= 1'b0;
      ref_level    <= INIT_REF;
      ref_valid    <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
    end else if (sym_en) begin
      slicer_out_I <= dec_i;
      slicer_out_Q <= dec_q;
      sym_valid    <= 1'b1;
      cnt          <= cnt + 1'b1;
      // The closing symbol was sliced with the old level above; the new level applies next.
      if (cnt == '1) begin
        ref_level <= acc_nxt[ACC_LOG2+1 +: 18];
        ref_valid <= 1'b1;
        acc       <= '0;
      end else begin
        acc <= acc_nxt;
      end
    end else begin
      sym_valid <= 1'b0;
    end
  end

`ifdef SLICER_ERROR_OUT_EN
  // Error against the reconstructed level (+-R/2, +-3R/2), saturated to 18 bits.
  function automatic logic signed [17:0] slice_err(input logic signed [17:0] x,
                                                   input logic [1:0] d,
                                                   input logic [17:0] r);
    logic signed [19:0] xs;
    logic signed [19:0] rs;
    logic signed [19:0] half;
    logic signed [19:0] lvl;
    logic signed [19:0] diff;
    xs   = {{2{x[17]}}, x};
    rs   = {2'b00, r};
    half = rs >>> 1;
    case (d)
      2'b00:   lvl = -(rs + half);
      2'b01:   lvl = -half;
      2'b10:   lvl = half;
      default: lvl = rs + half;
    endcase
    diff = xs - lvl;
    if (diff > 20'sd131072 - 20'sd1) return 18'sh1ffff;
    else if (diff < -20'sd131072)    return 18'sh20000;
    else                             return diff[17:0];
  endfunction

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      error_I <= '0;
      error_Q <= '0;
    end else if (sym_en) begin
      error_I <= slice_err(dec_in_I, dec_i, ref_level);
      error_Q <= slice_err(dec_in_Q, dec_q, ref_level);
    end
  end
`else
  assign error_I = '0;
  assign error_Q = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adaptive_slicer.sv
// Self-checking bench for adaptive_slicer (ACC_LOG2=4) against a queue-based reference model.
`default_nettype none

module tb_adaptive_slicer;

  localparam int ACC_LOG2 = 4;
  localparam int BLK      = 1 << ACC_LOG2;
  localparam int INIT_R   = 32768;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic signed [17:0] dec_in_I = '0;
  logic signed [17:0] dec_in_Q = '0;
  logic [1:0]         slicer_out_I;
  logic [1:0]         slicer_out_Q;
  logic               sym_valid;
  logic [17:0]        ref_level;
  logic               ref_valid;
  logic signed [17:0] error_I;
  logic signed [17:0] error_Q;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ref;
  int m_valid;
  int m_blk[$];
  int exp_I, exp_Q, exp_eI, exp_eQ;

  adaptive_slicer #(.ACC_LOG2(ACC_LOG2), .INIT_REF(18'sd32768)) dut (
    .sys_clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .dec_in_I(dec_in_I), .dec_in_Q(dec_in_Q),
    .slicer_out_I(slicer_out_I), .slicer_out_Q(slicer_out_Q), .sym_valid(sym_valid),
    .ref_level(ref_level), .ref_valid(ref_valid), .error_I(error_I), .error_Q(error_Q)
  );

  always #5 clk = ~clk;

  function automatic int m_abs(int x);
    if (x == -131072) return 131071;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int m_slice(int x, int r);
    if (x < -r) return 0;
    if (x < 0)  return 1;
    if (x < r)  return 2;
    return 3;
  endfunction

  function automatic int m_err(int x, int d, int r);
    int lv[4];
    int e;
    lv[0] = -(r + r / 2); lv[1] = -(r / 2); lv[2] = r / 2; lv[3] = r + r / 2;
    e = x - lv[d];
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
`ifdef SLICER_ERROR_OUT_EN
    return e;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset(input bit with_sym);
    @(negedge clk);
    reset = 1'b1;
    sam_clk_en = with_sym; sym_clk_en = with_sym;
    dec_in_I = 18'sd50000; dec_in_Q = -18'sd50000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    m_ref = INIT_R; m_valid = 0; m_blk.delete();
    exp_I = 2; exp_Q = 2; exp_eI = 0; exp_eQ = 0;
  endtask

  // Drives one symbol and advances the model; returns at the next falling edge.
  task automatic drive_sym(input int i, input int q);
    int tot;
    @(negedge clk);
    sam_clk_en = 1'b1; sym_clk_en = 1'b1;
    dec_in_I = 18'(i); dec_in_Q = 18'(q);
    exp_I  = m_slice(i, m_ref);
    exp_Q  = m_slice(q, m_ref);
    exp_eI = m_err(i, exp_I, m_ref);
    exp_eQ = m_err(q, exp_Q, m_ref);
    m_blk.push_back(m_abs(i) + m_abs(q));
    if (m_blk.size() == BLK) begin
      tot = 0;
      foreach (m_blk[k]) tot += m_blk[k];
      m_ref = tot / (2 * BLK);
      m_valid = 1;
      m_blk.delete();
    end
    @(negedge clk);
    sam_clk_en = 1'b0; sym_clk_en = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    checks++; if (slicer_out_I !== 2'b10 || slicer_out_Q !== 2'b10) begin errors++;
      $display("FAIL reset_slicer got %b/%b want 10/10", slicer_out_I, slicer_out_Q); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid got %b want 0", sym_valid); end
    checks++; if (ref_level !== 18'd32768) begin errors++; $display("FAIL reset_ref got %0d want 32768", ref_level); end
    checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL reset_ref_valid got %b want 0", ref_valid); end
    checks++; if (error_I !== 18'sd0 || error_Q !== 18'sd0) begin errors++;
      $display("FAIL reset_error got %0d/%0d want 0/0", error_I, error_Q); end
  endtask

  task automatic test_first_symbol;
    drive_sym(40000, -40000);
    checks++; if (slicer_out_I !== 2'b11 || slicer_out_Q !== 2'b00 || sym_valid !== 1'b1) begin errors++;
      $display("FAIL first_sym got %b/%b v=%b want 11/00 v=1", slicer_out_I, slicer_out_Q, sym_valid); end
    @(negedge clk);
    checks++; if (sym_valid !== 1'b0 || slicer_out_I !== 2'b11 || slicer_out_Q !== 2'b00) begin errors++;
      $display("FAIL first_sym_hold got %b/%b v=%b want 11/00 v=0", slicer_out_I, slicer_out_Q, sym_valid); end
  endtask

  task automatic test_block;
    int si, sq;
    do_reset(1'b0);
    for (int n = 0; n < BLK; n++) begin
      si = ($urandom % 2) ? 20000 : -20000;
      sq = ($urandom % 2) ? 20000 : -20000;
      drive_sym(si, sq);
      if (n < BLK - 1) begin
        checks++; if (ref_valid !== 1'b0 || ref_level !== 18'd32768) begin errors++;
          $display("FAIL block_early n=%0d ref=%0d v=%b want 32768 v=0", n, ref_level, ref_valid); end
      end
    end
    checks++; if (slicer_out_I !== ((si > 0) ? 2'b10 : 2'b01) || slicer_out_Q !== ((sq > 0) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL block_last_old_ref got %b/%b for %0d/%0d", slicer_out_I, slicer_out_Q, si, sq); end
    checks++; if (ref_level !== 18'd20000 || ref_valid !== 1'b1) begin errors++;
      $display("FAIL block_ref got %0d v=%b want 20000 v=1", ref_level, ref_valid); end
  endtask

  task automatic test_boundaries;
    int xv[6] = '{19999, 20000, 0, -1, -20000, -20001};
    logic [1:0] dv[6] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00};
    for (int k = 0; k < 6; k++) begin
      drive_sym(xv[k], -xv[k]);
      checks++; if (slicer_out_I !== dv[k]) begin errors++;
        $display("FAIL boundary x=%0d got %b want %b", xv[k], slicer_out_I, dv[k]); end
    end
  endtask

  task automatic test_saturation;
    drive_sym(-131072, 0);
    checks++; if (slicer_out_I !== 2'b00 || slicer_out_Q !== 2'b10) begin errors++;
      $display("FAIL sat_slice got %b/%b want 00/10", slicer_out_I, slicer_out_Q); end
  endtask

  task automatic test_error;
    int want;
`ifdef SLICER_ERROR_OUT_EN
    want = 1000;
`else
    want = 0;
`endif
    drive_sym(31000, -9000);
    checks++; if (error_I !== 18'(want)) begin errors++;
      $display("FAIL error_I got %0d want %0d", error_I, want); end
    checks++; if (error_Q !== 18'(exp_eQ)) begin errors++;
      $display("FAIL error_Q got %0d want %0d", error_Q, exp_eQ); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    for (int n = 0; n < 10; n++) drive_sym(60000, -60000);
    do_reset(1'b1);
    checks++; if (ref_level !== 18'd32768 || ref_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_ref got %0d v=%b want 32768 v=0", ref_level, ref_valid); end
    for (int n = 0; n < BLK; n++) begin
      drive_sym(int'($urandom_range(0, 80000)) - 40000, int'($urandom_range(0, 80000)) - 40000);
      if (n == BLK - 2) begin
        checks++; if (ref_valid !== 1'b0) begin errors++;
          $display("FAIL midreset_early got v=%b want 0", ref_valid); end
      end
    end
    checks++; if (ref_valid !== 1'b1 || ref_level !== 18'(m_ref)) begin errors++;
      $display("FAIL midreset_block got %0d v=%b want %0d v=1", ref_level, ref_valid, m_ref); end
  endtask

  task automatic test_random;
    int i, q, gap;
    for (int n = 0; n < 80; n++) begin
      if ($urandom % 2) begin
        i = int'($urandom_range(0, 262143)) - 131072;
        q = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        i = m_ref + int'($urandom_range(0, 4)) - 2;
        q = -m_ref + int'($urandom_range(0, 4)) - 2;
      end
      drive_sym(i, q);
      checks++;
      if (slicer_out_I !== 2'(exp_I) || slicer_out_Q !== 2'(exp_Q) || sym_valid !== 1'b1 ||
          ref_level !== 18'(m_ref) || ref_valid !== 1'(m_valid) ||
          error_I !== 18'(exp_eI) || error_Q !== 18'(exp_eQ)) begin
        errors++;
        $display("FAIL random n=%0d got %b/%b v=%b ref=%0d rv=%b e=%0d/%0d want %0d/%0d ref=%0d rv=%0d e=%0d/%0d",
                 n, slicer_out_I, slicer_out_Q, sym_valid, ref_level, ref_valid, error_I, error_Q,
                 exp_I, exp_Q, m_ref, m_valid, exp_eI, exp_eQ);
      end
      gap = $urandom % 3;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        sam_clk_en = 1'($urandom % 2);
        dec_in_I = 18'($urandom); dec_in_Q = 18'($urandom);
      end
      sam_clk_en = 1'b0;
      if (gap > 0) begin
        checks++;
        if (sym_valid !== 1'b0 || slicer_out_I !== 2'(exp_I) || slicer_out_Q !== 2'(exp_Q)) begin
          errors++;
          $display("FAIL random_hold n=%0d got %b/%b v=%b want %0d/%0d v=0",
                   n, slicer_out_I, slicer_out_Q, sym_valid, exp_I, exp_Q);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_first_symbol;
    test_block;
    test_boundaries;
    test_saturation;
    test_error;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adaptive_slicer.md
ADAPTIVE_SLICER -- requirements
Module: adaptive_slicer

Interface
REQ-001 Parameter ACC_LOG2, default 18, log2 of the number of symbols per reference-level averaging block (legal range 2..20).
REQ-002 Parameter INIT_REF, default 18'sd32768, reference level in use until the first averaging block completes.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sam_clk_en  input  1  one-cycle sample-rate enable.
REQ-006 sym_clk_en  input  1  one-cycle symbol-rate enable, coincident with a sam_clk_en cycle.
REQ-007 dec_in_I, dec_in_Q  input  18 each  signed 1s17 matched-filter/decimator outputs.
REQ-008 slicer_out_I, slicer_out_Q  output  2 each  registered 4-ASK decisions, feeding the BER block's slicer_in_I/Q.
REQ-009 sym_valid  output  1  one-cycle strobe marking new decisions.
REQ-010 ref_level  output  18  unsigned current decision threshold (mean |x|).
REQ-011 ref_valid  output  1  high once at least one averaging block has completed.
REQ-012 error_I, error_Q  output  18 each  signed slicing error (present only per REQ-027).

Function
REQ-013 Decisions are made only in cycles where sym_clk_en=1; inputs are otherwise ignored.
REQ-014 Decision map with R=ref_level: x < -R -> 2'b00; -R <= x < 0 -> 2'b01; 0 <= x < R -> 2'b10; x >= R -> 2'b11.
REQ-015 slicer_out_I/Q and sym_valid update on the edge ending the sym_clk_en cycle; latency is exactly 1 sys_clk; outputs hold between symbols; sym_valid is high for one cycle.
REQ-016 |x| is computed with saturation: |-131072| = 131071.
REQ-017 Accumulator of width 19+ACC_LOG2 adds |I|+|Q| each sym_clk_en cycle; symbol counter of width ACC_LOG2 increments each sym_clk_en cycle and wraps.
REQ-018 In the sym_clk_en cycle where the counter equals 2^ACC_LOG2-1: ref_level <= (acc + |I|+|Q|) >> (ACC_LOG2+1), acc <= 0, ref_valid <= 1; the counter wraps to 0.
REQ-019 The new ref_level applies to decisions from the following symbol onward; the symbol closing the block is sliced with the old level.
REQ-020 The accumulator never overflows by construction (width rule REQ-017); no clipping is applied to ref_level.
REQ-021 Reconstructed level L: 00 -> -3R/2, 01 -> -R/2, 10 -> +R/2, 11 -> +3R/2 (R/2 = R>>1, 3R/2 = R + (R>>1)); error = x - L, saturated to the 18-bit signed range, registered with the decisions.
REQ-022 sam_clk_en without sym_clk_en has no effect on any state.

Reset
REQ-023 While reset=1 at an edge: slicer_out_I/Q=2'b10, sym_valid=0, ref_level=INIT_REF, ref_valid=0, error_I/Q=0, accumulator=0, counter=0.
REQ-024 Reset overrides a coincident sym_clk_en; no decision, accumulation or block completion occurs in that cycle.
REQ-025 Reset asserted mid-block discards the partial accumulation; the next block starts fresh at counter 0 after reset is released.
REQ-026 The first sym_clk_en after reset release produces a decision using INIT_REF.

Configuration
REQ-027 Macro SLICER_ERROR_OUT_EN: when defined, error_I/error_Q logic per REQ-021 is compiled in; when undefined, the ports remain and are tied to 0, and no error subtractors exist.

Verification
REQ-028 Reset, INIT_REF=32768, one symbol I=40000, Q=-40000 -> next cycle slicer_out_I=11, slicer_out_Q=00, sym_valid=1 for one cycle.
REQ-029 ACC_LOG2=4, 16 symbols with |I|=|Q|=20000 -> after the 16th symbol ref_level=20000, ref_valid=1; the 16th symbol is still sliced against 32768.
REQ-030 Boundaries at R=20000: I=19999 -> 10, 20000 -> 11, 0 -> 10, -1 -> 01, -20000 -> 01, -20001 -> 00.
REQ-031 I=-131072 -> |x| saturates to 131071 in the accumulator; slicer_out_I=00.
REQ-032 Reset asserted after 10 of 16 symbols -> ref_level returns to 32768; the block completes only after 16 further symbols.
REQ-033 With SLICER_ERROR_OUT_EN defined, R=20000, I=31000 -> error_I=1000; with the macro undefined -> error_I=0.
